// File: rtl/simple_ctr_array_if.sv
// ============================================================================
// Module      : simple_ctr_array_if
// Description : Qualifier inputs, clock-buffer enable and counter outputs
//               bundled for simple_ctr_array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simple_ctr_array_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 4
);
    logic [NUM_CH-1:0]       inp1;
    logic [NUM_CH-1:0]       inp2;
    logic                    lcb_en;
    logic [NUM_CH-1:0]       out;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       tc;

    modport master (
        output inp1, inp2, lcb_en,
        input  out, count, tc
    );

    modport slave (
        input  inp1, inp2, lcb_en,
        output out, count, tc
    );
endinterface

`default_nettype wire

// File: rtl/simple_ctr_array.sv
// ============================================================================
// Module      : simple_ctr_array
// Description : NUM_CH independent armed counters with pipelined LSB output
//               and registered terminal-count pulse. Optional register-enable
//               gating from lcb_en when SIMPLE_LCB_GATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simple_ctr_array #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 4,
    parameter int OUT_STAGES = 2,
    parameter int SAT        = 0
) (
    input  wire              iccad_clk,
    input  wire              iccad_rst_n,
    simple_ctr_array_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX    = '1;
    localparam logic [WIDTH-1:0] MAX_M1 = MAX - WIDTH'(1);

    logic [NUM_CH-1:0][WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]            tc_q,  tc_d;
    logic [NUM_CH-1:0]            lsb;
    logic                         en;

`ifdef SIMPLE_LCB_GATE_EN
    assign en = bus.lcb_en;
`else
    logic unused_lcb_en;
    assign unused_lcb_en = bus.lcb_en;
    assign en            = 1'b1;
`endif

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = '0;
        if (en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.inp1[c] & bus.inp2[c]) begin
                    tc_d[c] = (cnt_q[c] == MAX_M1);
                    if (cnt_q[c] != MAX)
                        cnt_d[c] = cnt_q[c] + WIDTH'(1);
                    else if (SAT != 0)
                        cnt_d[c] = MAX;
                    else
                        cnt_d[c] = '0;
                end else begin
                    cnt_d[c] = '0;
                end
            end
        end
    end

    always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n) begin
            cnt_q <= '0;
            tc_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    always_comb begin
        lsb = '0;
        for (int c = 0; c < NUM_CH; c++)
            lsb[c] = cnt_q[c][0];
    end

    // The pipeline taps the registered counter LSB, so out trails count[0]
    // by exactly OUT_STAGES edges and freezes together with the counter.
    if (OUT_STAGES > 0) begin : g_pipe
        logic [OUT_STAGES-1:0][NUM_CH-1:0] out_q, out_d;

        always_comb begin
            out_d = out_q;
            if (en) begin
                out_d[0] = lsb;
                for (int s = 1; s < OUT_STAGES; s++)
                    out_d[s] = out_q[s-1];
            end
        end

        always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
            if (!iccad_rst_n)
                out_q <= '0;
            else
                out_q <= out_d;
        end

        assign bus.out = out_q[OUT_STAGES-1];
    end else begin : g_comb
        assign bus.out = lsb;
    end

    assign bus.count = cnt_q;
    assign bus.tc    = tc_q;

endmodule

`default_nettype wire

// File: tb/tb_simple_ctr_array.sv
// ============================================================================
// Module      : tb_simple_ctr_array
// Description : Scoreboard bench for simple_ctr_array: a wrapping 4x4-bit
//               instance (2 out stages) and a saturating 2x3-bit instance
//               (combinational out) share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simple_ctr_array;

    logic clk;
    logic rst_n;

    simple_ctr_array_if #(.NUM_CH(4), .WIDTH(4)) bus_a ();
    simple_ctr_array_if #(.NUM_CH(2), .WIDTH(3)) bus_b ();

    simple_ctr_array #(.NUM_CH(4), .WIDTH(4), .OUT_STAGES(2), .SAT(0)) dut_a (
        .iccad_clk   (clk),
        .iccad_rst_n (rst_n),
        .bus         (bus_a)
    );

    simple_ctr_array #(.NUM_CH(2), .WIDTH(3), .OUT_STAGES(0), .SAT(1)) dut_b (
        .iccad_clk   (clk),
        .iccad_rst_n (rst_n),
        .bus         (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ac;
        logic [3:0]  ao;
        logic [3:0]  at;
        logic [5:0]  bc;
        logic [1:0]  bo;
        logic [1:0]  bt;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model: d=0 is the 4-bit wrapping instance, d=1 the 3-bit
    // saturating one. hist[d][c][k] is the counter LSB k enabled edges ago.
    int m_cnt  [2][4];
    bit m_tc   [2][4];
    bit m_hist [2][4][5];

    function automatic int nch(input int d);   return (d == 0) ? 4 : 2; endfunction
    function automatic int wid(input int d);   return (d == 0) ? 4 : 3; endfunction
    function automatic bit sat(input int d);   return (d == 0) ? 1'b0 : 1'b1; endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin
                m_cnt[d][c] = 0;
                m_tc[d][c]  = 1'b0;
                for (int k = 0; k < 5; k++) m_hist[d][c][k] = 1'b0;
            end
    endtask

    task automatic model_step(input logic [3:0] i1, input logic [3:0] i2, input logic en_in);
        bit en;
        int maxv;
        en = 1'b1;
`ifdef SIMPLE_LCB_GATE_EN
        en = en_in;
`else
        if (en_in === 1'bx) en = 1'b1;
`endif
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < nch(d); c++) begin
                maxv = (1 << wid(d)) - 1;
                if (!en) begin
                    m_tc[d][c] = 1'b0;
                end else begin
                    if (i1[c] && i2[c]) begin
                        m_tc[d][c] = (m_cnt[d][c] == maxv - 1);
                        if (m_cnt[d][c] == maxv) m_cnt[d][c] = sat(d) ? maxv : 0;
                        else                     m_cnt[d][c] = m_cnt[d][c] + 1;
                    end else begin
                        m_tc[d][c]  = 1'b0;
                        m_cnt[d][c] = 0;
                    end
                    for (int k = 4; k > 0; k--) m_hist[d][c][k] = m_hist[d][c][k-1];
                    m_hist[d][c][0] = m_cnt[d][c][0];
                end
            end
    endtask

    function automatic exp_t make_exp();
        exp_t e;
        int   v;
        e.ac = '0; e.ao = '0; e.at = '0; e.bc = '0; e.bo = '0; e.bt = '0;
        for (int c = 0; c < 4; c++) begin
            v = m_cnt[0][c];
            e.ac[c*4 +: 4] = v[3:0];
            e.ao[c]        = m_hist[0][c][2];
            e.at[c]        = m_tc[0][c];
        end
        for (int c = 0; c < 2; c++) begin
            v = m_cnt[1][c];
            e.bc[c*3 +: 3] = v[2:0];
            e.bo[c]        = m_hist[1][c][0];
            e.bt[c]        = m_tc[1][c];
        end
        return e;
    endfunction

    task automatic cycle(input logic rst, input logic [3:0] i1, input logic [3:0] i2, input logic en);
        @(negedge clk);
        rst_n        = rst;
        bus_a.inp1   = i1;
        bus_a.inp2   = i2;
        bus_a.lcb_en = en;
        bus_b.inp1   = i1[1:0];
        bus_b.inp2   = i2[1:0];
        bus_b.lcb_en = en;
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step(i1, i2, en);
        sb.push_back(make_exp());
    endtask

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("a_count", bus_a.count, e.ac);
                chk("a_out",   bus_a.out,   e.ao);
                chk("a_tc",    bus_a.tc,    e.at);
                chk("b_count", bus_b.count, e.bc);
                chk("b_out",   bus_b.out,   e.bo);
                chk("b_tc",    bus_b.tc,    e.bt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [3:0] i1, i2;
        logic       en;
        int         r;

        rst_n        = 1'b0;
        bus_a.inp1   = '1; bus_a.inp2 = '1; bus_a.lcb_en = 1'b1;
        bus_b.inp1   = '1; bus_b.inp2 = '1; bus_b.lcb_en = 1'b1;
        model_reset();

        // Held in reset with everything armed.
        repeat (5) cycle(1'b0, 4'hF, 4'hF, 1'b1);

        // Count all channels to 5, then assert reset between edges.
        repeat (5) cycle(1'b1, 4'hF, 4'hF, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_a_count", bus_a.count, 32'd0);
        chk("async_rst_a_out",   bus_a.out,   32'd0);
        chk("async_rst_a_tc",    bus_a.tc,    32'd0);
        chk("async_rst_b_count", bus_b.count, 32'd0);
        cycle(1'b0, 4'hF, 4'hF, 1'b1);

        // Wrap / saturate on channel 0, then drop the arm mid-count.
        repeat (27) cycle(1'b1, 4'b0001, 4'b0001, 1'b1);
        cycle(1'b1, 4'b0001, 4'b0000, 1'b1);

        // Only channels 1 and 3 armed.
        repeat (10) cycle(1'b1, 4'b1010, 4'b1010, 1'b1);
        cycle(1'b1, 4'b0000, 4'b1111, 1'b1);

        // Count to 9, hold lcb_en low for three edges, then re-enable.
        repeat (9) cycle(1'b1, 4'hF, 4'hF, 1'b1);
        repeat (3) cycle(1'b1, 4'hF, 4'hF, 1'b0);
        repeat (2) cycle(1'b1, 4'hF, 4'hF, 1'b1);

        // Randomised arming biased towards long runs, random gating.
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 15) != 0) begin
                    i1[c] = 1'b1; i2[c] = 1'b1;
                end else begin
                    r = int'($urandom_range(0, 2));
                    i1[c] = (r == 1);
                    i2[c] = (r == 2);
                end
            end
            en = ($urandom_range(0, 7) != 0);
            cycle(1'b1, i1, i2, en);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
